conv_result_writer: RTL and testbench



---
 rtl/conv_result_writer_pkg.sv | 30 +++
 rtl/xilinx_single_port_ram_no_change.sv | 55 +++++
 rtl/conv_result_writer.sv | 163 ++++++++++++++++
 tb/tb_conv_result_writer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_result_writer_pkg.sv
// Shared types and helpers for the convolution write-back path.
package conv_result_writer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      READY   = 2'd2,
      DRAIN   = 2'd3
   } state_t;

   // Bits needed to hold values 0..value; never returns less than 1.
   function automatic int unsigned clogb2(input int unsigned value);
      int unsigned d;
      int unsigned n;
      d = value;
      n = 0;
      while (d > 0) begin
         n = n + 1;
         d = d >> 1;
      end
      return (n == 0) ? 1 : n;
   endfunction

   // Valid-convolution output dimension.
   function automatic int unsigned out_dim(input int unsigned image_dim,
                                           input int unsigned kernel_dim);
      return image_dim - kernel_dim + 1;
   endfunction

endpackage

// File: rtl/xilinx_single_port_ram_no_change.sv
// Single-port block RAM, no-change mode: output holds during writes.
module xilinx_single_port_ram_no_change
   import conv_result_writer_pkg::*;
#(
   parameter int unsigned RAM_WIDTH       = 8,
   parameter int unsigned RAM_DEPTH       = 64,
   parameter string       RAM_PERFORMANCE = "LOW_LATENCY"
) (
   input  logic [clogb2(RAM_DEPTH-1)-1:0] addra,
   input  logic [RAM_WIDTH-1:0]           dina,
   input  logic                           clka,
   input  logic                           wea,
   input  logic                           ena,
   input  logic                           rsta,
   input  logic                           regcea,
   output logic [RAM_WIDTH-1:0]           douta
);

   logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
   logic [RAM_WIDTH-1:0] ram_data;

   always_ff @(posedge clka) begin
      if (ena && wea) begin
         mem[addra] <= dina;
      end
   end

   // Read latch updates only on non-write cycles; rsta clears the latch.
   always_ff @(posedge clka) begin
      if (rsta) begin
         ram_data <= '0;
      end else if (ena && !wea) begin
         ram_data <= mem[addra];
      end
   end

   generate
      if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
         logic unused_regcea;
         assign unused_regcea = regcea;
         assign douta = ram_data;
      end else begin : g_high_performance
         logic [RAM_WIDTH-1:0] douta_reg;
         always_ff @(posedge clka) begin
            if (rsta) begin
               douta_reg <= '0;
            end else if (regcea) begin
               douta_reg <= ram_data;
            end
         end
         assign douta = douta_reg;
      end
   endgenerate

endmodule

// File: rtl/conv_result_writer.sv
// Collects column-major convolution results into raster-ordered BRAM, then streams them out.
module conv_result_writer
   import conv_result_writer_pkg::*;
#(
   parameter int unsigned RAM_WIDTH    = 8,
   parameter int unsigned IMAGE_WIDTH  = 10,
   parameter int unsigned IMAGE_HEIGHT = 10,
   parameter int unsigned KERNEL_WIDTH = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_start,
   input  logic                 i_valid_result,
   input  logic [RAM_WIDTH-1:0] i_result,
   input  logic                 i_valid_get_frame,
   output logic                 o_ready_for_result,
   output logic                 o_is_frame_ready,
   output logic [RAM_WIDTH-1:0] o_data_from_mem,
   output logic                 o_valid_data,
   output logic                 o_overflow
);

   localparam int unsigned OUT_W      = out_dim(IMAGE_WIDTH, KERNEL_WIDTH);
   localparam int unsigned OUT_H      = out_dim(IMAGE_HEIGHT, KERNEL_WIDTH);
   localparam int unsigned OUT_PIXELS = OUT_W * OUT_H;
   localparam int unsigned AW         = clogb2(OUT_PIXELS - 1);
   localparam int unsigned RW         = clogb2(OUT_H - 1);
   localparam int unsigned CW         = clogb2(OUT_W - 1);

   state_t               state;
   state_t               next_state;
   logic [RW-1:0]        row;
   logic [CW-1:0]        col;
   logic [AW-1:0]        wr_addr;
   logic [AW-1:0]        rd_addr;
   logic [AW-1:0]        ram_addr;
   logic [RAM_WIDTH-1:0] ram_dout;
   logic                 ram_rst;

   logic start_ok;
   logic accept;
   logic last_row;
   logic last_write;
   logic rd_en;
   logic last_read;
   logic ready_d;
   logic frame_ready_d;
   logic overflow_d;

   assign start_ok   = (state == IDLE) && i_start;
   assign accept     = (state == COLLECT) && i_valid_result;
   assign last_row   = (row == RW'(OUT_H - 1));
   assign last_write = accept && last_row && (col == CW'(OUT_W - 1));
   assign rd_en      = (state == READY) && i_valid_get_frame;
   assign last_read  = rd_en && (rd_addr == AW'(OUT_PIXELS - 1));

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (i_start) next_state = COLLECT;
         COLLECT: if (last_write) next_state = READY;
         READY:   if (last_read) next_state = DRAIN;
         DRAIN:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output decode, computed one cycle ahead so the flags are registered.
   always_comb begin
      ready_d       = 1'b0;
      frame_ready_d = 1'b0;
      overflow_d    = o_overflow;
      case (next_state)
         COLLECT:      ready_d = 1'b1;
         READY, DRAIN: frame_ready_d = 1'b1;
         default:      ;
      endcase
      if (start_ok) begin
         overflow_d = 1'b0;
      end
      if (i_valid_result && (state != COLLECT)) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_ready_for_result <= 1'b0;
         o_is_frame_ready   <= 1'b0;
         o_overflow         <= 1'b0;
         o_valid_data       <= 1'b0;
      end else begin
         o_ready_for_result <= ready_d;
         o_is_frame_ready   <= frame_ready_d;
         o_overflow         <= overflow_d;
         o_valid_data       <= rd_en;
      end
   end

   // Column-major arrival mapped to raster addresses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row     <= '0;
         col     <= '0;
         wr_addr <= '0;
      end else if (start_ok) begin
         row     <= '0;
         col     <= '0;
         wr_addr <= '0;
      end else if (accept) begin
         if (!last_row) begin
            row     <= row + RW'(1);
            wr_addr <= wr_addr + AW'(OUT_W);
         end else begin
            row     <= '0;
            col     <= col + CW'(1);
            wr_addr <= AW'(col) + AW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_addr <= '0;
      end else if (last_write) begin
         rd_addr <= '0;
      end else if (rd_en) begin
         rd_addr <= rd_addr + AW'(1);
      end
   end

   assign ram_addr = (state == COLLECT) ? wr_addr : rd_addr;
   assign ram_rst  = ~reset;

   xilinx_single_port_ram_no_change #(
      .RAM_WIDTH       (RAM_WIDTH),
      .RAM_DEPTH       (OUT_PIXELS),
      .RAM_PERFORMANCE ("LOW_LATENCY")
   ) u_ram (
      .addra  (ram_addr),
      .dina   (i_result),
      .clka   (clk),
      .wea    (accept),
      .ena    (1'b1),
      .rsta   (ram_rst),
      .regcea (1'b1),
      .douta  (ram_dout)
   );

   // Pixel bus is qualified by valid so it reads zero whenever no pixel is presented.
   assign o_data_from_mem = o_valid_data ? ram_dout : '0;

endmodule

// File: tb/tb_conv_result_writer.sv
// Directed bench for conv_result_writer: 10x10 input, 3x3 kernel, 8x8 output frame.
module tb_conv_result_writer;

   localparam int unsigned W   = 8;
   localparam int unsigned N   = 8;
   localparam int unsigned PIX = N * N;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         i_start = 1'b0;
   logic         i_valid_result = 1'b0;
   logic [W-1:0] i_result = '0;
   logic         i_valid_get_frame = 1'b0;
   logic         o_ready_for_result;
   logic         o_is_frame_ready;
   logic [W-1:0] o_data_from_mem;
   logic         o_valid_data;
   logic         o_overflow;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   conv_result_writer #(
      .RAM_WIDTH    (W),
      .IMAGE_WIDTH  (10),
      .IMAGE_HEIGHT (10),
      .KERNEL_WIDTH (3)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .i_start            (i_start),
      .i_valid_result     (i_valid_result),
      .i_result           (i_result),
      .i_valid_get_frame  (i_valid_get_frame),
      .o_ready_for_result (o_ready_for_result),
      .o_is_frame_ready   (o_is_frame_ready),
      .o_data_from_mem    (o_data_from_mem),
      .o_valid_data       (o_valid_data),
      .o_overflow         (o_overflow)
   );

   typedef struct {
      logic         start;
      logic         vres;
      logic         get;
      logic [W-1:0] res;
      logic         e_ready;
      logic         e_fr;
      logic         e_valid;
      logic         e_ovf;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_flags(input string tag, input logic rdy, input logic fr,
                            input logic vld, input logic ovf);
      chk({tag, "_ready"},       32'(o_ready_for_result), 32'(rdy));
      chk({tag, "_frame_ready"}, 32'(o_is_frame_ready),   32'(fr));
      chk({tag, "_valid"},       32'(o_valid_data),       32'(vld));
      chk({tag, "_overflow"},    32'(o_overflow),         32'(ovf));
   endtask

   // Raster pixel p = (r,c) was written as column-major index c*8+r.
   function automatic int exp_pix(input int kind, input int p);
      int k;
      k = (p % N) * N + p / N;
      return (kind == 0) ? k : 200 - k;
   endfunction

   function automatic logic [W-1:0] frame_val(input int kind, input int k);
      return (kind == 0) ? W'(k) : W'(200 - k);
   endfunction

   task automatic send_result(input logic [W-1:0] v);
      i_valid_result = 1'b1;
      i_result       = v;
      tick();
      i_valid_result = 1'b0;
   endtask

   task automatic read_frame(input int kind, input int first, output int nvalid);
      nvalid = 0;
      i_valid_get_frame = 1'b1;
      for (int p = first; p < int'(PIX); p++) begin
         tick();
         if (o_valid_data === 1'b1) nvalid++;
         chk($sformatf("rd%0d_valid_p%0d", kind, p), 32'(o_valid_data), 32'd1);
         chk($sformatf("rd%0d_data_p%0d", kind, p), 32'(o_data_from_mem), 32'(exp_pix(kind, p)));
         if (kind == 0 && p == 1) chk("col_wrap", 32'(o_data_from_mem), 32'd8);
      end
      i_valid_get_frame = 1'b0;
   endtask

   task automatic drain_checks(input string tag);
      chk({tag, "_drain_frame_ready"}, 32'(o_is_frame_ready), 32'd1);
      tick();
      chk({tag, "_idle_valid"},       32'(o_valid_data),       32'd0);
      chk({tag, "_idle_frame_ready"}, 32'(o_is_frame_ready),   32'd0);
      chk({tag, "_idle_ready"},       32'(o_ready_for_result), 32'd0);
   endtask

   initial begin
      int nv;
      int total;

      //                 start vres get  res    rdy fr  vld ovf
      tbl[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[2] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b1, 1'b0, 8'd1,  1'b1, 1'b0, 1'b0, 1'b0};
      tbl[7] = '{1'b1, 1'b1, 1'b1, 8'd2,  1'b1, 1'b0, 1'b0, 1'b0};

      // Reset state
      #2 reset = 1'b0;
      #1;
      chk_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("reset_data", 32'(o_data_from_mem), 32'd0);
      tick();
      tick();
      @(negedge clk);
      reset = 1'b1;

      // Overflow in IDLE, start, ignored controls, first writes
      for (int i = 0; i < 8; i++) begin
         i_start           = tbl[i].start;
         i_valid_result    = tbl[i].vres;
         i_valid_get_frame = tbl[i].get;
         i_result          = tbl[i].res;
         tick();
         chk_flags($sformatf("tbl%0d", i), tbl[i].e_ready, tbl[i].e_fr,
                   tbl[i].e_valid, tbl[i].e_ovf);
      end
      i_start = 1'b0;
      i_valid_result = 1'b0;
      i_valid_get_frame = 1'b0;

      // Rest of frame 1
      for (int k = 3; k < int'(PIX) - 1; k++) send_result(frame_val(0, k));
      chk("pre_final_ready", 32'(o_ready_for_result), 32'd1);
      chk("pre_final_frame_ready", 32'(o_is_frame_ready), 32'd0);
      send_result(frame_val(0, int'(PIX) - 1));
      chk_flags("final_write", 1'b0, 1'b1, 1'b0, 1'b0);

      // Stray result in READY must not touch RAM at rd_addr 0
      send_result(8'hFF);
      chk_flags("ovf_ready", 1'b0, 1'b1, 1'b0, 1'b1);

      // Single request latency
      i_valid_get_frame = 1'b1;
      tick();
      i_valid_get_frame = 1'b0;
      chk("lat_valid", 32'(o_valid_data), 32'd1);
      chk("lat_pixel0", 32'(o_data_from_mem), 32'd0);
      total = (o_valid_data === 1'b1) ? 1 : 0;
      tick();
      chk("lat_no_req_valid", 32'(o_valid_data), 32'd0);
      tick();
      chk("lat_no_req_valid2", 32'(o_valid_data), 32'd0);

      read_frame(0, 1, nv);
      total += nv;
      drain_checks("f1");
      chk("f1_valid_count", 32'(total), 32'(PIX));
      chk("f1_ovf_sticky", 32'(o_overflow), 32'd1);

      // Get request in IDLE ignored
      i_valid_get_frame = 1'b1;
      tick();
      i_valid_get_frame = 1'b0;
      chk("idle_get_valid", 32'(o_valid_data), 32'd0);
      tick();
      chk("idle_get_valid2", 32'(o_valid_data), 32'd0);

      // Start clears overflow; abandon frame with async reset
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      chk_flags("f2_start", 1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) send_result(frame_val(1, 40 + k));
      chk("mid_ready", 32'(o_ready_for_result), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk_flags("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("mid_reset_data", 32'(o_data_from_mem), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      chk_flags("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);

      // Fresh frame after reset
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      chk("f3_start_ready", 32'(o_ready_for_result), 32'd1);
      for (int k = 0; k < int'(PIX); k++) send_result(frame_val(1, k));
      chk_flags("f3_final", 1'b0, 1'b1, 1'b0, 1'b0);
      read_frame(1, 0, nv);
      drain_checks("f3");
      chk("f3_valid_count", 32'(nv), 32'(PIX));
      chk("f3_ovf", 32'(o_overflow), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
